// File: rtl/counter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl_if
//  Description : Bundles the user-facing signals of counter_ctrl: raw keys,
//                mode and saturation controls, the load strobe with its value,
//                and the count/wrap/tick results.
//  Ports       : key_inc, key_dec  raw active-low buttons (master -> slave)
//                mode[1:0]         00 manual, 01 auto-up, 10 auto-down, 11 hold
//                sat_en            1 saturate at limits, 0 wrap
//                load, load_val    synchronous load strobe and value
//                count             registered counter value (slave -> master)
//                wrap              one-cycle pulse on a wrap-around step
//                tick              one-cycle pulse every TICK_DIV cycles
//  Revision    : 1.0 - initial release
// ============================================================================
interface counter_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             key_inc;
    logic             key_dec;
    logic [1:0]       mode;
    logic             sat_en;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             wrap;
    logic             tick;

    // Drives controls, observes results.
    modport master (
        output key_inc, key_dec, mode, sat_en, load, load_val,
        input  count, wrap, tick
    );

    // The counter itself.
    modport slave (
        input  key_inc, key_dec, mode, sat_en, load, load_val,
        output count, wrap, tick
    );
endinterface
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : counter_ctrl
//  Description : Up/down counter driven by two debounced push buttons with
//                auto-repeat, or by a free-running tick divider in the auto
//                modes. Supports a synchronous load and saturate/wrap limits.
//  Ports       : clock_50  system clock
//                reset_n   synchronous active-low reset
//                bus       counter_ctrl_if.slave (keys, mode, sat_en, load,
//                          load_val in; count, wrap, tick out). The interface
//                          WIDTH must equal this module's WIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
module counter_ctrl #(
    parameter int WIDTH         = 8,
    parameter int TICK_DIV      = 50_000_000,
    parameter int DEBOUNCE      = 500_000,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  wire logic       clock_50,
    input  wire logic       reset_n,
    counter_ctrl_if.slave   bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_DB_W  = $clog2(DEBOUNCE);
    localparam int c_RP_MX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RP_W  = $clog2(c_RP_MX);
    localparam int c_DIV_W = $clog2(TICK_DIV);

    localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE - 1);
    localparam logic [c_RP_W-1:0]  c_RD_LAST  = c_RP_W'(REPEAT_DELAY - 1);
    localparam logic [c_RP_W-1:0]  c_RP_LAST  = c_RP_W'(REPEAT_PERIOD - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0]   c_CNT_MAX  = '1;

    localparam logic [1:0] c_MODE_MANUAL = 2'b00;
    localparam logic [1:0] c_MODE_UP     = 2'b01;
    localparam logic [1:0] c_MODE_DOWN   = 2'b10;

    // Per-key state: IDLE is the accepted "released" level; DELAY and REPEAT
    // are both the accepted "pressed" level, differing only in which
    // auto-repeat interval is being timed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_t;

    // Index 0 = increment key, index 1 = decrement key.
    logic [1:0] w_key_raw;
    logic [1:0] w_key_ev;

    assign w_key_raw = {bus.key_dec, bus.key_inc};

    // ------------------------------------------------------------------------
    // Key path: 2-flop synchroniser -> debouncer -> press/repeat events.
    // A clean pin edge appears in sync2 two edges later, is accepted after
    // DEBOUNCE more differing samples, and the registered event then moves
    // the count on the following edge.
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < 2; k++) begin : g_key
        logic              sync1_q;
        logic              sync2_q;
        key_state_t        st_q, st_d;
        logic [c_DB_W-1:0] db_cnt_q, db_cnt_d;
        logic [c_RP_W-1:0] rep_cnt_q, rep_cnt_d;
        logic              ev_q, ev_d;
        logic              w_acc;
        logic              w_diff;
        logic              w_flip;

        assign w_acc  = (st_q == ST_IDLE);
        assign w_diff = (sync2_q != w_acc);
        // The accepted level flips on the DEBOUNCE-th consecutive differing
        // sample; any agreeing sample clears the run.
        assign w_flip = w_diff && (db_cnt_q == c_DB_LAST);

        always_comb begin
            db_cnt_d  = '0;
            st_d      = st_q;
            rep_cnt_d = rep_cnt_q;
            ev_d      = 1'b0;

            if (w_diff && !w_flip) begin
                db_cnt_d = db_cnt_q + 1'b1;
            end

            case (st_q)
                ST_IDLE: begin
                    if (w_flip) begin
                        st_d      = ST_DELAY;
                        rep_cnt_d = '0;
                        ev_d      = 1'b1;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    // Release wins over a repeat due on the same edge.
                    if (w_flip) begin
                        st_d      = ST_IDLE;
                        rep_cnt_d = '0;
                    end else if (rep_cnt_q == ((st_q == ST_DELAY) ? c_RD_LAST : c_RP_LAST)) begin
                        st_d      = ST_REPEAT;
                        rep_cnt_d = '0;
                        ev_d      = 1'b1;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 1'b1;
                    end
                end
                default: begin
                    st_d      = ST_IDLE;
                    rep_cnt_d = '0;
                end
            endcase
        end

        always_ff @(posedge clock_50) begin
            if (!reset_n) begin
                sync1_q   <= 1'b1;
                sync2_q   <= 1'b1;
                st_q      <= ST_IDLE;
                db_cnt_q  <= '0;
                rep_cnt_q <= '0;
                ev_q      <= 1'b0;
            end else begin
                sync1_q   <= w_key_raw[k];
                sync2_q   <= sync1_q;
                st_q      <= st_d;
                db_cnt_q  <= db_cnt_d;
                rep_cnt_q <= rep_cnt_d;
                ev_q      <= ev_d;
            end
        end

        assign w_key_ev[k] = ev_q;
    end

    // ------------------------------------------------------------------------
    // Tick divider: free-running regardless of mode.
    // ------------------------------------------------------------------------
    logic [c_DIV_W-1:0] div_q, div_d;
    logic               w_tick;

    assign w_tick = (div_q == c_DIV_LAST);
    assign div_d  = w_tick ? '0 : div_q + 1'b1;

    // ------------------------------------------------------------------------
    // Counter update: load, then the current mode's step request.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             w_up;
    logic             w_down;

    always_comb begin
        w_up   = 1'b0;
        w_down = 1'b0;
        case (bus.mode)
            c_MODE_MANUAL: begin
                // Simultaneous inc and dec events cancel.
                w_up   = w_key_ev[0] & ~w_key_ev[1];
                w_down = w_key_ev[1] & ~w_key_ev[0];
            end
            c_MODE_UP:   w_up   = w_tick;
            c_MODE_DOWN: w_down = w_tick;
            default: begin
                w_up   = 1'b0;
                w_down = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.load) begin
            count_d = bus.load_val;
        end else if (w_up) begin
            if (count_q != c_CNT_MAX) begin
                count_d = count_q + 1'b1;
            end else if (!bus.sat_en) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end
        end else if (w_down) begin
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else if (!bus.sat_en) begin
                count_d = c_CNT_MAX;
                wrap_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_50) begin
        if (!reset_n) begin
            div_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    assign bus.tick  = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_counter_ctrl
//  Description : Directed bench for counter_ctrl (WIDTH=4, TICK_DIV=10,
//                DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=5). Every count
//                change the stimulus expects is queued; a monitor pops one
//                entry per observed change. Cycle-exact points are checked
//                inline. Inputs change 1 time unit after a rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_ctrl;

    localparam int c_W = 4;

    logic clock_50 = 1'b0;
    logic reset_n  = 1'b0;

    always #5 clock_50 = ~clock_50;

    counter_ctrl_if #(.WIDTH(c_W)) bus ();

    counter_ctrl #(
        .WIDTH         (c_W),
        .TICK_DIV      (10),
        .DEBOUNCE      (4),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut (
        .clock_50 (clock_50),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    typedef struct {
        logic [c_W-1:0] cnt;
        logic           wrap;
    } exp_t;

    exp_t           exp_q[$];
    int             vectors     = 0;
    int             miscompares = 0;
    logic           mon_en      = 1'b0;
    logic [c_W-1:0] prev_cnt    = '0;

    task automatic step(input int n);
        repeat (n) @(posedge clock_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [c_W-1:0] cnt, input logic wrap);
        exp_t e;
        e.cnt  = cnt;
        e.wrap = wrap;
        exp_q.push_back(e);
    endtask

    task automatic do_load(input logic [c_W-1:0] v);
        bus.load     = 1'b1;
        bus.load_val = v;
        step(1);
        bus.load     = 1'b0;
    endtask

    // Bounded wait until tick is high in the current cycle.
    task automatic wait_tick(input string tag);
        int n;
        n = 0;
        while (bus.tick !== 1'b1 && n < 20) begin
            step(1);
            n++;
        end
        chk(tag, 32'(bus.tick), 32'd1);
    endtask

    // Scoreboard monitor: every count change must match the next queued entry;
    // wrap may only be high together with a change.
    always @(negedge clock_50) begin
        if (mon_en) begin
            if (bus.count !== prev_cnt) begin
                vectors++;
                assert (exp_q.size() != 0) else begin
                    miscompares++;
                    $error("FAIL sb_unexpected: observed count %0d wrap %0d expected no change from %0d",
                           bus.count, bus.wrap, prev_cnt);
                end
                if (exp_q.size() != 0) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    vectors++;
                    assert ({bus.count, bus.wrap} === {e.cnt, e.wrap}) else begin
                        miscompares++;
                        $error("FAIL sb_change: observed count %0d wrap %0d expected count %0d wrap %0d",
                               bus.count, bus.wrap, e.cnt, e.wrap);
                    end
                end
            end else begin
                vectors++;
                assert (bus.wrap === 1'b0) else begin
                    miscompares++;
                    $error("FAIL sb_wrap_idle: observed wrap %0d expected 0 with count %0d", bus.wrap, bus.count);
                end
            end
            prev_cnt = bus.count;
        end
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no end of test expected finish before 50000");
        $fatal(1, "timeout");
    end

    initial begin
        logic wrap_seen;

        bus.key_inc  = 1'b1;
        bus.key_dec  = 1'b1;
        bus.mode     = 2'b00;
        bus.sat_en   = 1'b0;
        bus.load     = 1'b0;
        bus.load_val = '0;

        // ---------------- reset state ----------------
        step(3);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_wrap",  32'(bus.wrap),  32'd0);
        chk("rst_tick",  32'(bus.tick),  32'd0);
        reset_n  = 1'b1;
        prev_cnt = bus.count;
        mon_en   = 1'b1;

        // ---------------- bounce, press, auto-repeat ----------------
        push(4'd3, 1'b0);
        do_load(4'd3);
        chk("load3", 32'(bus.count), 32'd3);
        for (int i = 0; i < 3; i++) begin
            bus.key_inc = 1'b0;
            step(3);
            bus.key_inc = 1'b1;
            step(3);
        end
        push(4'd4, 1'b0);
        push(4'd5, 1'b0);
        push(4'd6, 1'b0);
        bus.key_inc = 1'b0;                 // stable press from here
        step(6);
        chk("press_before", 32'(bus.count), 32'd3);
        step(1);                            // 7 cycles after the stable edge
        chk("press_lat", 32'(bus.count), 32'd4);
        step(19);
        chk("rep_before", 32'(bus.count), 32'd4);
        step(1);
        chk("rep_first", 32'(bus.count), 32'd5);
        step(3);
        bus.key_inc = 1'b1;                 // released 30 cycles after press
        step(2);
        chk("rep_second", 32'(bus.count), 32'd6);
        step(10);
        chk("rep_stop", 32'(bus.count), 32'd6);

        // ---------------- simultaneous inc and dec ----------------
        push(4'd7, 1'b0);
        do_load(4'd7);
        bus.key_inc = 1'b0;
        bus.key_dec = 1'b0;
        step(12);
        chk("both_count", 32'(bus.count), 32'd7);
        chk("both_wrap",  32'(bus.wrap),  32'd0);
        bus.key_inc = 1'b1;
        bus.key_dec = 1'b1;
        step(10);
        chk("both_after", 32'(bus.count), 32'd7);

        // ---------------- auto-up with wrap ----------------
        push(4'd14, 1'b0);
        do_load(4'd14);
        wait_tick("up_tick_found");
        bus.mode = 2'b01;
        push(4'd15, 1'b0);
        push(4'd0,  1'b1);
        step(1);
        chk("up_15", 32'(bus.count), 32'd15);
        chk("up_tick_low", 32'(bus.tick), 32'd0);
        step(9);
        chk("up_tick_period", 32'(bus.tick), 32'd1);
        chk("up_hold_15", 32'(bus.count), 32'd15);
        step(1);
        chk("up_0", 32'(bus.count), 32'd0);
        chk("up_wrap", 32'(bus.wrap), 32'd1);
        bus.mode = 2'b11;
        step(1);
        chk("up_wrap_end", 32'(bus.wrap), 32'd0);

        // ---------------- auto-down with saturation ----------------
        bus.sat_en = 1'b1;
        push(4'd1, 1'b0);
        do_load(4'd1);
        wait_tick("down_tick_found");
        bus.mode = 2'b10;
        push(4'd0, 1'b0);
        step(1);
        chk("down_0", 32'(bus.count), 32'd0);
        wrap_seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (bus.wrap === 1'b1) wrap_seen = 1'b1;
        end
        chk("down_sat", 32'(bus.count), 32'd0);
        chk("down_nowrap", 32'(wrap_seen), 32'd0);

        // ---------------- hold mode, then load over a press event ----------------
        bus.mode   = 2'b11;
        bus.sat_en = 1'b0;
        bus.key_inc = 1'b0;
        step(12);
        bus.key_inc = 1'b1;
        bus.key_dec = 1'b0;
        step(12);
        bus.key_dec = 1'b1;
        step(10);
        chk("hold_frozen", 32'(bus.count), 32'd0);
        bus.key_inc = 1'b0;
        step(6);                            // press event lands on the next edge
        bus.mode     = 2'b00;
        bus.load     = 1'b1;
        bus.load_val = 4'd9;
        push(4'd9, 1'b0);
        step(1);
        bus.load = 1'b0;
        chk("load_over_press", 32'(bus.count), 32'd9);
        step(3);
        bus.key_inc = 1'b1;
        step(12);
        chk("load_no_inc", 32'(bus.count), 32'd9);

        // ---------------- reset mid-press ----------------
        push(4'd12, 1'b0);
        do_load(4'd12);
        bus.key_dec = 1'b0;
        step(2);
        reset_n = 1'b0;
        push(4'd0, 1'b0);
        step(1);
        chk("rst_mid_count", 32'(bus.count), 32'd0);
        chk("rst_mid_wrap",  32'(bus.wrap),  32'd0);
        step(2);
        chk("rst_mid_tick", 32'(bus.tick), 32'd0);
        reset_n = 1'b1;
        step(1);                            // first edge out of reset
        step(5);
        chk("rst_repress_before", 32'(bus.count), 32'd0);
        push(4'd15, 1'b1);
        step(1);                            // 6 cycles after the release edge
        chk("rst_repress_count", 32'(bus.count), 32'd15);
        chk("rst_repress_wrap",  32'(bus.wrap),  32'd1);
        bus.key_dec = 1'b1;
        step(1);
        chk("rst_repress_pulse", 32'(bus.wrap), 32'd0);

        // ---------------- manual increment saturates at max ----------------
        bus.sat_en  = 1'b1;
        bus.key_inc = 1'b0;
        step(8);
        bus.key_inc = 1'b1;
        step(12);
        chk("sat_max", 32'(bus.count), 32'd15);

        step(2);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/counter_ctrl.md
COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 Parameter WIDTH, 8, count width in bits (2..32).
REQ-002 Parameter TICK_DIV, 50_000_000, clock_50 cycles per auto-mode tick (>=2).
REQ-003 Parameter DEBOUNCE, 500_000, consecutive stable cycles needed to accept a key level (>=2).
REQ-004 Parameter REPEAT_DELAY, 25_000_000, held-key cycles before auto-repeat starts (>DEBOUNCE).
REQ-005 Parameter REPEAT_PERIOD, 5_000_000, cycles between auto-repeat events (>=2).
REQ-006 Reset is reset_n, synchronous, active-low; clock is clock_50.
REQ-007 clock_50  in  1  system clock.
REQ-008 reset_n  in  1  synchronous active-low reset.
REQ-009 key_inc  in  1  raw asynchronous increment button, active-low (0 = pressed).
REQ-010 key_dec  in  1  raw asynchronous decrement button, active-low.
REQ-011 mode  in  2  00 manual, 01 auto-up, 10 auto-down, 11 hold.
REQ-012 sat_en  in  1  1 = saturate at limits, 0 = wrap.
REQ-013 load  in  1  synchronous load strobe, level-sampled each cycle.
REQ-014 load_val  in  WIDTH  value written on load.
REQ-015 count  out  WIDTH  registered counter value.
REQ-016 wrap  out  1  one-cycle pulse on overflow or underflow wrap.
REQ-017 tick  out  1  one-cycle pulse every TICK_DIV cycles.

Function
REQ-018 Each key passes through a 2-flop synchroniser before any other logic.
REQ-019 Debouncer per key: the accepted level changes only after the synchronised level differs from it for DEBOUNCE consecutive cycles; any bounce restarts the stability count.
REQ-020 Press event: a one-cycle pulse when the accepted level goes 1->0; release produces no event.
REQ-021 Auto-repeat: while the accepted level stays 0, a further event fires REPEAT_DELAY cycles after the press event, then every REPEAT_PERIOD cycles; it stops immediately on accepted release.
REQ-022 Latency from a clean key pin edge to the count change is exactly DEBOUNCE+3 cycles.
REQ-023 Tick divider free-runs 0..TICK_DIV-1; tick is high in the cycle where the divider equals TICK_DIV-1, independent of mode.
REQ-024 Update priority per cycle: load > mode action > no change.
REQ-025 load=1: count <= load_val, wrap stays 0, key events that cycle are discarded.
REQ-026 Manual mode: an inc event alone gives +1, a dec event alone gives -1, and both in the same cycle cancel (no change, no wrap).
REQ-027 Auto-up or auto-down: +1 or -1 on each tick; key events are discarded; debouncers keep running.
REQ-028 Hold mode: count frozen; key events and ticks are discarded.
REQ-029 sat_en=0: arithmetic modulo 2^WIDTH; wrap pulses in the cycle count moves 2^WIDTH-1->0 or 0->2^WIDTH-1.
REQ-030 sat_en=1: +1 at 2^WIDTH-1 and -1 at 0 leave count unchanged; wrap stays 0.
REQ-031 Mode or sat_en changes take effect on the next clock edge; no event is queued across a mode change.

Reset
REQ-032 reset_n=0 at a clock edge forces count=0, wrap=0, tick=0, divider=0, synchronisers=1, accepted levels=1 (released), and all debounce and repeat counters=0.
REQ-033 Reset mid-press: after release of reset a key held low is re-debounced and yields a fresh press event after DEBOUNCE+2 cycles.
REQ-034 Reset overrides load and all mode actions.

Verification (WIDTH=4, TICK_DIV=10, DEBOUNCE=4, REPEAT_DELAY=20, REPEAT_PERIOD=5)
REQ-035 Manual, count=3: key_inc low with 3-cycle bounces, then stable 30 cycles, then released -> count 4 at 7 cycles after the stable edge, then 5 and 6 from auto-repeat, then no further change.
REQ-036 Manual, count=7: key_inc and key_dec pressed on the same cycle -> count stays 7, wrap=0.
REQ-037 Auto-up, sat_en=0, load 14 -> count 15 then 0 on successive ticks; wrap pulses once on the 15->0 step; ticks 10 cycles apart.
REQ-038 Auto-down, sat_en=1, count=1 -> 0 on the next tick and stays 0 on all later ticks; wrap never asserts.
REQ-039 Hold mode with key presses and ticks, then load=1 with load_val=9 and key_inc pressed -> count 9 only and no increment from that press.
REQ-040 Reset asserted while count=12 and key_dec held -> count 0 on the next edge; after reset release with the key still held, count 15 (sat_en=0) 6 cycles later with one wrap pulse.
